// File: rtl/demux_router_pkg.sv
// demux_router_pkg: shared constants and FSM state type for the 1-to-2 stream demux
package demux_router_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = 16;
  typedef enum logic {ST_IDLE, ST_ROUTE} state_t;
endpackage

// File: rtl/demux_router_if.sv
// demux_router_if: input stream plus two output streams; slave is the router, master is source/consumers
interface demux_router_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic in_sel;
  logic in_last;
  logic out0_valid;
  logic out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic out0_last;
  logic out1_valid;
  logic out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic out1_last;
  modport slave (
    input in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );
  modport master (
    output in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
    input in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );
endinterface

// File: rtl/demux_fifo2.sv
// demux_fifo2: 2-entry registered FIFO with occupancy counter and 1-bit wrapping pointers
module demux_fifo2
  import demux_router_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  assign full = cnt == 2'(FIFO_DEPTH);
  assign empty = cnt == 2'd0;
  assign head = mem[rp];
  // storage, pointers and occupancy; push while full / pop while empty are excluded by the caller
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/demux_router.sv
// demux_router: 1-to-2 packet demux with per-port 2-deep FIFOs; DEMUX_ROUTER_CNT_EN adds packet counters
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  demux_router_if.slave bus
`ifdef DEMUX_ROUTER_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);
  state_t state;
  logic route, sel, acc, push0, push1, pop0, pop1, full0, full1, empty0, empty1;
  logic [WIDTH:0] head0, head1;
  assign sel = state == ST_IDLE ? bus.in_sel : route;
  assign bus.in_ready = sel ? !full1 : !full0;
  assign acc = bus.in_valid && bus.in_ready;
  assign push0 = acc && !sel;
  assign push1 = acc && sel;
  assign pop0 = bus.out0_valid && bus.out0_ready;
  assign pop1 = bus.out1_valid && bus.out1_ready;
  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;
  assign bus.out0_data = head0[WIDTH-1:0];
  assign bus.out0_last = head0[WIDTH];
  assign bus.out1_data = head1[WIDTH-1:0];
  assign bus.out1_last = head1[WIDTH];
  demux_fifo2 #(.W(WIDTH + 1)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .pop(pop0),
    .din({bus.in_last, bus.in_data}), .full(full0), .empty(empty0), .head(head0)
  );
  demux_fifo2 #(.W(WIDTH + 1)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .pop(pop1),
    .din({bus.in_last, bus.in_data}), .full(full1), .empty(empty1), .head(head1)
  );
  // packet FSM: lock the route on the first beat of a multi-beat packet, release on last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      route <= 1'b0;
    end else if (acc) begin
      if (state == ST_IDLE && !bus.in_last) route <= bus.in_sel;
      state <= bus.in_last ? ST_IDLE : ST_ROUTE;
    end
`ifdef DEMUX_ROUTER_CNT_EN
  // saturating counts of completed packets delivered on each port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0 && bus.out0_last && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
      if (pop1 && bus.out1_last && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
    end
`endif
endmodule

// File: doc/demux_router.md
# demux_router

1-to-2 stream demultiplexer, the inverse of the team's 2:1 `a`/`b`/`sel` selector. A single valid/ready input stream is routed to one of two output streams. The route is selected per packet: `in_sel` is sampled on the first beat and held until the beat carrying `in_last`. Each output is decoupled by a 2-entry registered FIFO, so there is no combinational path from output ready to input ready. The block sits between a shared source and two independent consumers.

## Interface
- `WIDTH`, default 8: data width in bits of each beat.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: input beat accepted when `in_valid && in_ready`.
- `in_data` input WIDTH: beat payload.
- `in_sel` input 1: route, 0 = out0, 1 = out1. Sampled on the first beat of a packet only.
- `in_last` input 1: final beat of the packet.
- `out0_valid` output 1, `out0_ready` input 1, `out0_data` output WIDTH, `out0_last` output 1: port 0 stream.
- `out1_valid` output 1, `out1_ready` input 1, `out1_data` output WIDTH, `out1_last` output 1: port 1 stream.
- `cnt0`, `cnt1` output 16 each: packet counters. Present only with `DEMUX_ROUTER_CNT_EN`.

## Operation
- **FSM states:** IDLE and ROUTE. A register `route` holds the locked port.
- **IDLE:**
  - The effective select is `in_sel`.
  - An accepted beat with `in_last=0` latches `route<=in_sel` and moves to ROUTE.
  - An accepted beat with `in_last=1` is a single-beat packet; the FSM stays in IDLE.
- **ROUTE:**
  - The effective select is `route`; `in_sel` is ignored.
  - An accepted beat with `in_last=1` returns the FSM to IDLE.
- **Input ready:** `in_ready = !full[effective select]`, derived from registered FIFO state only. A full non-selected FIFO never stalls the input.
- **Push:** an accepted beat pushes `{in_last, in_data}` into the selected FIFO only. The other FIFO is untouched.
- **Output side:** `outN_valid = !emptyN`. The FIFO head drives `outN_data` and `outN_last`. A pop occurs on `outN_valid && outN_ready`.
- **FIFO:** depth 2, with a 2-bit occupancy counter and 1-bit read and write pointers that wrap modulo 2.
  - Push and pop in the same cycle leave occupancy unchanged and are legal when occupancy is 1.
  - When full, no push occurs, because `in_ready` is low for that port.
  - When empty, a pop is impossible because valid is low.
- **Ordering:** beat order is preserved per port. Packets are never interleaved within a port.
- **Reset (any time, including mid-packet):**
  - The FSM goes to IDLE.
  - Both FIFOs are emptied and their pointers zeroed.
  - Any partial packet is discarded with no `last` flush.

## Timing
- **Reset values:**
  - `in_ready=1`, because both FIFOs are empty.
  - `out0_valid=0`, `out1_valid=0`.
  - `out*_data=0`, `out*_last=0`, because FIFO storage is reset to 0.
  - `cnt0=0`, `cnt1=0`.
- **Latency:** an input beat accepted at edge k is presented with `outN_valid=1` from edge k onward, i.e. visible in cycle k+1. Minimum latency is 1 cycle.
- **Throughput:** 1 beat/cycle sustained while the selected consumer holds ready high.
- **`in_ready` timing:** reflects occupancy after the previous edge. It depends combinationally only on the effective select (`in_sel` in IDLE).
- **Backpressure:** two beats are buffered per port. With `outN_ready` held low, `in_ready` drops after the second accepted beat to that port.
- **Source rules:** the source holds `in_data`, `in_sel` and `in_last` stable while `in_valid` is high and `in_ready` is low. The block itself never depends on this for correctness.

## Configuration
- **`DEMUX_ROUTER_CNT_EN` defined:**
  - Ports `cnt0` and `cnt1` exist.
  - `cntN` increments by 1 on each popped beat from port N with `outN_last=1`, i.e. completed packets delivered.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Both reset to 0.
- **Undefined:** the ports and counter logic are absent. All other behaviour is identical.

## Structure
- **Shared package `demux_router_pkg`:**
  - localparam `FIFO_DEPTH=2`.
  - State enum `{ST_IDLE, ST_ROUTE}`.
  - Localparam `CNT_W=16`.
- **Sub-module `demux_fifo2`:** parameterised by WIDTH+1, with push/pop/full/empty and head output. Instantiated twice.
- **Top level** holds only the FSM, the select mux and the counters.

## Test plan
- Reset, then single-beat packet `in_sel=1`, `in_data=8'hA5`, `in_last=1`, with `out1_ready=1` → `out1_valid` high one cycle later with `out1_data=A5`, `out1_last=1`; `out0_valid` stays 0.
- 3-beat packet 11,22,33 with `in_sel=0` on beat 1 and `in_sel` toggled to 1 on beats 2–3 → all three beats appear on out0 in order, `last` only on 33; out1 sees nothing.
- `out0_ready=0`, send 4 beats to port 0 → `in_ready` falls after 2 accepts. Raise `out0_ready` → remaining beats pass in order with no loss or duplication.
- Port 0 full and stalled, then a new packet with `in_sel=1` → `in_ready=1` and the packet flows to out1 unimpeded.
- Assert `rst_n=0` mid-packet with data buffered → both `outN_valid` go 0 immediately (asynchronous). After release, the FSM is in IDLE, so the next beat's `in_sel` is honoured.
- With `DEMUX_ROUTER_CNT_EN`: deliver 5 packets to port 1 → `cnt1=5`, `cnt0=0`. Force the counter near saturation → it stops at FFFF.
